// File: rtl/mac_dot_sequencer_pkg.sv
// Shared definitions for the MAC dot-product sequencer: state encoding,
// operand/accumulator widths and the default product length limit.
package mac_dot_sequencer_pkg;

    localparam int OP_W        = 16;
    localparam int ACC_W       = 36;
    localparam int MAX_LEN_DEF = 16;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Drives operand pairs into a MAC one per cycle, clears the accumulator before
// each dot product and returns the captured sum over a valid/ready result port.
module mac_dot_sequencer
    import mac_dot_sequencer_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int MAC_LAT = 1,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [CNT_W-1:0] res_count,
    output logic             res_trunc
);

    localparam int DW = $clog2(MAC_LAT + 2) + 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] count;
    logic [DW-1:0]    dcnt;
    logic             beat;
    logic             terminal;
    logic             drain_done;

    // Handshake and clear are pure decodes of the state register, so they
    // come up in their reset values as soon as the state does.
    assign in_ready   = (state == ST_RUN);
    assign mac_clr    = (state == ST_CLEAR);
    assign beat       = in_valid & in_ready;
    assign terminal   = beat & (in_last | (count == CNT_W'(MAX_LEN - 1)));
    assign drain_done = (state == ST_DRAIN) && (dcnt == DW'(MAC_LAT + 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_CLEAR;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: state_nx = ST_RUN;
            ST_RUN:   if (terminal) state_nx = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_nx = ST_DONE;
            ST_DONE:  if (res_valid && res_ready) state_nx = ST_CLEAR;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_a     <= '0;
            mac_b     <= '0;
            count     <= '0;
            dcnt      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            res_trunc <= 1'b0;
        end else begin
            // Zero operands on idle cycles keep the accumulator holding.
            mac_a <= beat ? in_a : '0;
            mac_b <= beat ? in_b : '0;
            case (state)
                ST_CLEAR: count <= '0;
                ST_RUN: begin
                    if (beat) count <= count + CNT_W'(1);
                    if (terminal) begin
                        res_trunc <= ~in_last;
                        dcnt      <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Capture only after the last product has reached mac_acc.
                    if (drain_done) begin
                        res_data  <= mac_acc;
                        res_count <= count;
                        res_valid <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                ST_DONE: if (res_ready) res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural MAC, stream-level dot-product model,
// per-cycle result comparison and directed vectors with literal expectations.
module tb_mac_dot_sequencer;

    localparam int MAX_LEN = 16;
    localparam int MAC_LAT = 1;
    localparam int CNT_W   = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic             in_last = 1'b0;
    logic [15:0]      mac_a, mac_b;
    logic             mac_clr;
    logic [35:0]      mac_acc;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [35:0]      res_data;
    logic [CNT_W-1:0] res_count;
    logic             res_trunc;

    mac_dot_sequencer #(.MAX_LEN(MAX_LEN), .MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_count(res_count), .res_trunc(res_trunc)
    );

    always #5 clk = ~clk;

    // MAC with a synchronous clear, one edge of latency
    logic [35:0] acc = '0;
    assign mac_acc = acc;
    always @(posedge clk) begin
        if (mac_clr) acc <= '0;
        else         acc <= acc + 36'(mac_a) * 36'(mac_b);
    end

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [35:0] d;
        int          c;
        logic        t;
    } res_t;

    res_t            exp_q[$];
    res_t            obs_q[$];
    longint          term_q[$];
    longint unsigned m_sum = 0;
    int              m_cnt = 0;
    int              nerr = 0;
    int              nchk = 0;
    logic            prev_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: got timeout/absent expected event", name);
    endtask

    // Stream model: products group by in_last or by reaching MAX_LEN pairs.
    task automatic model_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        res_t r;
        m_sum += longint'(a) * longint'(b);
        m_cnt++;
        if (last || m_cnt == MAX_LEN) begin
            r.d = m_sum[35:0];
            r.c = m_cnt;
            r.t = ~last;
            exp_q.push_back(r);
            term_q.push_back(cyc);
            m_sum = 0;
            m_cnt = 0;
        end
    endtask

    always @(negedge clk) begin
        if (reset && res_valid) begin
            if (!prev_valid) begin
                if (term_q.size() == 0) fail_now("latency_no_terminal");
                else chk("latency", 64'(cyc - term_q.pop_front()), 64'(MAC_LAT + 2));
            end
            chk("in_ready_while_result", in_ready, 0);
            if (exp_q.size() == 0) begin
                fail_now("unexpected_result");
            end else begin
                chk("res_data", res_data, exp_q[0].d);
                chk("res_count", res_count, exp_q[0].c);
                chk("res_trunc", res_trunc, exp_q[0].t);
                if (res_ready) begin
                    obs_q.push_back(exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
        prev_valid <= reset & res_valid;
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("send_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        model_pair(a, b, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_results();
        int n = 0;
        while ((exp_q.size() != 0 || res_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || res_valid) fail_now("result_timeout");
    endtask

    task automatic chk_obs(input int idx, input logic [35:0] d, input int c, input logic t);
        if (obs_q.size() <= idx) begin
            fail_now("result_missing");
        end else begin
            chk("lit_data", obs_q[idx].d, d);
            chk("lit_count", obs_q[idx].c, c);
            chk("lit_trunc", obs_q[idx].t, t);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_mac_clr"}, mac_clr, 1);
        chk({tag, "_mac_a"}, mac_a, 0);
        chk({tag, "_mac_b"}, mac_b, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_count"}, res_count, 0);
        chk({tag, "_res_trunc"}, res_trunc, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);

        // Two pairs back-to-back
        send(16'd12, 16'd20, 1'b0);
        send(16'd11, 16'd5, 1'b1);
        wait_results();
        chk_obs(0, 36'd295, 2, 1'b0);

        // Single full-scale pair
        send(16'hFFFF, 16'hFFFF, 1'b1);
        wait_results();
        chk_obs(1, 36'd4294836225, 1, 1'b0);

        // Truncation at MAX_LEN; the 17th pair carries into the next product
        for (int i = 0; i < 16; i++) send(16'hFFFF, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        wait_results();
        chk_obs(2, 36'd68717379600, 16, 1'b1);
        chk_obs(3, 36'd4294836225, 1, 1'b0);

        // Result held by back-pressure while a pair waits at the input
        res_ready = 1'b0;
        send(16'd7, 16'd8, 1'b1);
        begin
            int n = 0;
            while (!res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!res_valid) fail_now("hold_result_timeout");
        end
        in_valid = 1'b1;
        in_a     = 16'd9;
        in_b     = 16'd10;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 56);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_mac_a", mac_a, 0);
        end
        res_ready = 1'b1;
        send(16'd9, 16'd10, 1'b1);
        wait_results();
        chk_obs(4, 36'd56, 1, 1'b0);
        chk_obs(5, 36'd90, 1, 1'b0);

        // Gap between beats drives zero operands
        send(16'd3, 16'd4, 1'b0);
        chk("beat_mac_a", mac_a, 3);
        chk("beat_mac_b", mac_b, 4);
        @(negedge clk);
        chk("idle_mac_a", mac_a, 0);
        chk("idle_mac_b", mac_b, 0);
        send(16'd5, 16'd6, 1'b1);
        wait_results();
        chk_obs(6, 36'd42, 2, 1'b0);

        // Asynchronous reset in the middle of a product
        send(16'd100, 16'd100, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_values("async");
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(16'd2, 16'd3, 1'b1);
        wait_results();
        chk_obs(7, 36'd6, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
